// File: rtl/ro_freq_meter.sv
// ro_freq_meter: two-channel ring-oscillator frequency meter.
// Counts synchronized rising edges of each RO over a fixed gate window and
// publishes saturated 8-bit counts with a one-cycle valid strobe.
module ro_freq_meter #(
  parameter int unsigned GATE_CYCLES = 250,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       en,
  input  logic       RO_internal,
  input  logic       RO_external,
  output logic [7:0] freq_int,
  output logic [7:0] freq_ext,
  output logic       ovf_int,
  output logic       ovf_ext,
  output logic       valid
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 10;
  localparam int unsigned SET_W = 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    LATCH  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_nxt_c;

  logic [WIN_W-1:0] win_cnt_q;
  logic [SET_W-1:0] set_cnt_q;

  logic gate_c;
  logic keep_c;
  logic load_c;
  logic settle_step_c;

  logic [NCH-1:0]                  ro_c;
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NCH-1:0]                  hist_q;
  logic [NCH-1:0]                  rise_c;

  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  logic [NCH-1:0][CNT_W-1:0] cnt_nxt_c;
  logic [NCH-1:0]            sat_q;
  logic [NCH-1:0]            sat_nxt_c;

  // Channel 0 is the internal RO, channel 1 the external RO.
  assign ro_c = {RO_external, RO_internal};

  // Per-channel synchronizer chain plus history flop; runs in every state.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], ro_c[ch]};
        hist_q[ch] <= sync_q[ch][SYNC_STAGES-1];
      end
    end
  end

  // Rising-edge detect on the synchronized RO level.
  always_comb begin
    rise_c = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      rise_c[ch] = sync_q[ch][SYNC_STAGES-1] & ~hist_q[ch];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt_c;
    end
  end

  // FSM next-state logic; dropping en always wins, even in the last gate cycle.
  always_comb begin
    state_nxt_c = state_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_nxt_c = SETTLE;
        end
      end
      SETTLE: begin
        if (!en) begin
          state_nxt_c = IDLE;
        end else if (set_cnt_q == SET_LAST) begin
          state_nxt_c = GATE;
        end
      end
      GATE: begin
        if (!en) begin
          state_nxt_c = IDLE;
        end else if (win_cnt_q == WIN_LAST) begin
          state_nxt_c = LATCH;
        end
      end
      LATCH: begin
        state_nxt_c = en ? GATE : IDLE;
      end
      default: begin
        state_nxt_c = IDLE;
      end
    endcase
  end

  // FSM control outputs: count enable, stay-in-window, result load, settle step.
  always_comb begin
    gate_c        = 1'b0;
    keep_c        = 1'b0;
    load_c        = 1'b0;
    settle_step_c = 1'b0;
    if (state_q == GATE) begin
      gate_c = 1'b1;
      keep_c = (state_nxt_c == GATE);
      load_c = (state_nxt_c == LATCH);
    end
    if (state_q == SETTLE) begin
      settle_step_c = (state_nxt_c == SETTLE);
    end
  end

  // Settle counter: times the SYNC_STAGES cycles that flush the synchronizers.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      set_cnt_q <= '0;
    end else if (settle_step_c) begin
      set_cnt_q <= set_cnt_q + SET_W'(1);
    end else begin
      set_cnt_q <= '0;
    end
  end

  // Window counter: 0..GATE_CYCLES-1 while gating, cleared otherwise.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else if (keep_c) begin
      win_cnt_q <= win_cnt_q + WIN_W'(1);
    end else begin
      win_cnt_q <= '0;
    end
  end

  // Saturating edge count including this cycle's rise; feeds both counter and result load.
  always_comb begin
    cnt_nxt_c = cnt_q;
    sat_nxt_c = sat_q;
    for (int ch = 0; ch < NCH; ch++) begin
      if (gate_c && rise_c[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          sat_nxt_c[ch] = 1'b1;
        end else begin
          cnt_nxt_c[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Edge counters hold only while the window continues; any exit from GATE clears them.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= '0;
    end else if (keep_c) begin
      cnt_q <= cnt_nxt_c;
      sat_q <= sat_nxt_c;
    end else begin
      cnt_q <= '0;
      sat_q <= '0;
    end
  end

  // Result registers: load only on the GATE -> LATCH edge, hold otherwise.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      freq_int <= '0;
      freq_ext <= '0;
      ovf_int  <= 1'b0;
      ovf_ext  <= 1'b0;
    end else if (load_c) begin
      freq_int <= cnt_nxt_c[0];
      freq_ext <= cnt_nxt_c[1];
      ovf_int  <= sat_nxt_c[0];
      ovf_ext  <= sat_nxt_c[1];
    end
  end

  // Valid strobe is high for exactly the LATCH cycle.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else begin
      valid <= load_c;
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: three instances covering default parameters,
// a long saturating window and a minimal 2-cycle window.
module tb_ro_freq_meter;

  localparam int NS = 1000;

  logic clk;
  logic rst_n;

  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic on_ai = 1'b0, on_ae = 1'b0, on_bi = 1'b0, on_be = 1'b0, on_ci = 1'b0, on_ce = 1'b0;
  logic ro_ai = 1'b0, ro_ae = 1'b0, ro_bi = 1'b0, ro_be = 1'b0, ro_ci = 1'b0, ro_ce = 1'b0;

  logic [7:0] fi_a, fe_a, fi_b, fe_b, fi_c, fe_c;
  logic       oi_a, oe_a, oi_b, oe_b, oi_c, oe_c;
  logic       v_a, v_b, v_c;

  int total = 0;
  int bad   = 0;

  ro_freq_meter #(.GATE_CYCLES(250), .SYNC_STAGES(2)) u_a (
    .clk_50MHz(clk), .rst_n(rst_n), .en(en_a), .RO_internal(ro_ai), .RO_external(ro_ae),
    .freq_int(fi_a), .freq_ext(fe_a), .ovf_int(oi_a), .ovf_ext(oe_a), .valid(v_a));

  ro_freq_meter #(.GATE_CYCLES(1000), .SYNC_STAGES(2)) u_b (
    .clk_50MHz(clk), .rst_n(rst_n), .en(en_b), .RO_internal(ro_bi), .RO_external(ro_be),
    .freq_int(fi_b), .freq_ext(fe_b), .ovf_int(oi_b), .ovf_ext(oe_b), .valid(v_b));

  ro_freq_meter #(.GATE_CYCLES(2), .SYNC_STAGES(3)) u_c (
    .clk_50MHz(clk), .rst_n(rst_n), .en(en_c), .RO_internal(ro_ci), .RO_external(ro_ce),
    .freq_int(fi_c), .freq_ext(fe_c), .ovf_int(oi_c), .ovf_ext(oe_c), .valid(v_c));

  // 50 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #(10*NS) clk = ~clk;
  end

  // Ring oscillators: 20 MHz / 24 MHz / 10 MHz, held at 0 while disabled.
  initial begin #(3*NS); forever begin #(25*NS); ro_ai = on_ai ? ~ro_ai : 1'b0; end end
  initial begin #(3*NS); forever begin #20833;   ro_ae = on_ae ? ~ro_ae : 1'b0; end end
  initial begin #(3*NS); forever begin #(25*NS); ro_bi = on_bi ? ~ro_bi : 1'b0; end end
  initial begin #(3*NS); forever begin #20833;   ro_be = on_be ? ~ro_be : 1'b0; end end
  initial begin #(3*NS); forever begin #(50*NS); ro_ci = on_ci ? ~ro_ci : 1'b0; end end
  initial begin #(7*NS); forever begin #(50*NS); ro_ce = on_ce ? ~ro_ce : 1'b0; end end

  typedef struct {
    int dut;
    bit ri;
    bit re;
    int gap;
    int fi_lo, fi_hi;
    int fe_lo, fe_hi;
    int oi, oe;
  } vec_t;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // sel: 0 valid, 1 freq_int, 2 freq_ext, 3 ovf_int, 4 ovf_ext
  function automatic int obs(input int d, input int sel);
    case (d)
      0: case (sel) 0: return int'(v_a); 1: return int'(fi_a); 2: return int'(fe_a);
                    3: return int'(oi_a); default: return int'(oe_a); endcase
      1: case (sel) 0: return int'(v_b); 1: return int'(fi_b); 2: return int'(fe_b);
                    3: return int'(oi_b); default: return int'(oe_b); endcase
      default: case (sel) 0: return int'(v_c); 1: return int'(fi_c); 2: return int'(fe_c);
                    3: return int'(oi_c); default: return int'(oe_c); endcase
    endcase
  endfunction

  task automatic set_dut(input int d, input bit e, input bit ri, input bit re);
    case (d)
      0: begin en_a = e; on_ai = ri; on_ae = re; end
      1: begin en_b = e; on_bi = ri; on_be = re; end
      default: begin en_c = e; on_ci = ri; on_ce = re; end
    endcase
  endtask

  // Count negedges until valid of instance d is seen; -1 when the budget runs out.
  task automatic wait_valid(input int d, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (obs(d, 0) == 0 && n < budget);
    if (obs(d, 0) == 0) n = -1;
  endtask

  initial begin
    vec_t vt[10];
    int   n;
    int   sum_i, sum_e;
    bit   seen_v, held_bad;

    // dut, ri, re, gap, fi range, fe range, ovf_int, ovf_ext
    vt[0] = '{0, 1'b0, 1'b0, 253,   0,   0,   0,   0, 0, 0};
    vt[1] = '{0, 1'b0, 1'b0, 251,   0,   0,   0,   0, 0, 0};
    vt[2] = '{0, 1'b1, 1'b1, 251,   0, 101,   0, 121, 0, 0};
    vt[3] = '{0, 1'b1, 1'b1, 251,  99, 101, 119, 121, 0, 0};
    vt[4] = '{0, 1'b1, 1'b1, 251,  99, 101, 119, 121, 0, 0};
    vt[5] = '{0, 1'b1, 1'b1, 251,  99, 101, 119, 121, 0, 0};
    vt[6] = '{1, 1'b1, 1'b0, 1003, 255, 255,  0,   0, 1, 0};
    vt[7] = '{1, 1'b1, 1'b0, 1001, 255, 255,  0,   0, 1, 0};
    vt[8] = '{2, 1'b1, 1'b1, 6,     0,   1,   0,   1, 0, 0};
    vt[9] = '{2, 1'b1, 1'b1, 3,     0,   1,   0,   1, 0, 0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 5; s++) chk($sformatf("reset a sel%0d", s), obs(0, s), 0, 0);
    chk("reset b valid", obs(1, 0), 0, 0);
    chk("reset c valid", obs(2, 0), 0, 0);

    // Release mid-cycle: the current period is cycle 1.
    rst_n = 1'b1;
    set_dut(0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      set_dut(vt[i].dut, 1'b1, vt[i].ri, vt[i].re);
      wait_valid(vt[i].dut, vt[i].gap + 5, n);
      chk($sformatf("v%0d gap", i), n, vt[i].gap, vt[i].gap);
      chk($sformatf("v%0d freq_int", i), obs(vt[i].dut, 1), vt[i].fi_lo, vt[i].fi_hi);
      chk($sformatf("v%0d freq_ext", i), obs(vt[i].dut, 2), vt[i].fe_lo, vt[i].fe_hi);
      chk($sformatf("v%0d ovf_int", i), obs(vt[i].dut, 3), vt[i].oi, vt[i].oi);
      chk($sformatf("v%0d ovf_ext", i), obs(vt[i].dut, 4), vt[i].oe, vt[i].oe);
    end

    // en dropped at window cycle 100 of the long window: no valid, results hold.
    wait_valid(1, 1010, n);
    chk("b align", n, 1, 1001);
    repeat (101) @(negedge clk);
    set_dut(1, 1'b0, 1'b1, 1'b0);
    seen_v = 1'b0;
    held_bad = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (v_b) seen_v = 1'b1;
      if (fi_b != 8'd255 || fe_b != 8'd0 || oi_b != 1'b1 || oe_b != 1'b0) held_bad = 1'b1;
    end
    chk("en drop no valid", int'(seen_v), 0, 0);
    chk("en drop hold", int'(held_bad), 0, 0);
    set_dut(1, 1'b1, 1'b1, 1'b0);
    wait_valid(1, 1010, n);
    chk("en re-assert gap", n, 1003, 1003);
    chk("en re-assert freq_int", obs(1, 1), 255, 255);
    chk("en re-assert ovf_int", obs(1, 3), 1, 1);

    // Minimal window with 10 MHz ROs: rises every 5 cycles, one of every 3 cycles dead.
    wait_valid(2, 8, n);
    chk("c align", n, 1, 3);
    sum_i = 0;
    sum_e = 0;
    for (int k = 0; k < 15; k++) begin
      wait_valid(2, 8, n);
      chk($sformatf("c period %0d", k), n, 3, 3);
      sum_i += obs(2, 1);
      sum_e += obs(2, 2);
    end
    chk("c sum freq_int", sum_i, 6, 6);
    chk("c sum freq_ext", sum_e, 6, 6);

    // Reset pulse mid-window on a running meter with nonzero results.
    repeat (100) @(negedge clk);
    chk("pre-reset freq_int", obs(0, 1), 99, 101);
    #(5*NS);
    rst_n = 1'b0;
    #(1*NS);
    for (int s = 0; s < 5; s++) chk($sformatf("async reset sel%0d", s), obs(0, s), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(0, 260, n);
    chk("post-reset gap", n, 253, 253);
    chk("post-reset freq_int", obs(0, 1), 99, 101);
    chk("post-reset freq_ext", obs(0, 2), 119, 121);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
